// File: rtl/mem_responder.sv
// Bus-side responder for the DLX MAC handshake: word-addressed storage with WAIT_CYC wait states before a one-cycle ACK_N.
// Optional MEM_RESP_ERR_EN adds ERR and rejects addresses >= DEPTH instead of wrapping them.
module mem_responder #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              AS_N,
  input  logic              WR_N,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DI,
  output logic [DATA_W-1:0] DO,
  output logic              ACK_N,
  output logic              BUSY_RESP,
`ifdef MEM_RESP_ERR_EN
  output logic              ERR,
`endif
  output logic [1:0]        STATE
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT    = 2'b01,
    S_ACK     = 2'b10,
    S_RECOVER = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_n_q;
  logic [DATA_W-1:0] di_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              enter_ack;
  logic              oob;
  logic              unused_addr;

  assign idx         = addr_q[IDX_W-1:0];
  assign unused_addr = ^addr_q;
  assign BUSY_RESP   = (state_q != S_IDLE);
  assign STATE       = state_q;
  assign enter_ack   = (state_q == S_WAIT) && (state_d == S_ACK);

`ifdef MEM_RESP_ERR_EN
  // Widen by one bit so DEPTH == 2**ADDR_W does not truncate to zero.
  assign oob = ({1'b0, addr_q} >= (ADDR_W+1)'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!AS_N) state_d = S_WAIT;
      S_WAIT:    if (AS_N) state_d = S_IDLE;
                 else if (cnt_q == 4'd0) state_d = S_ACK;
      S_ACK:     state_d = S_RECOVER;
      S_RECOVER: if (AS_N) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ACK_N   <= 1'b1;
      DO      <= '0;
`ifdef MEM_RESP_ERR_EN
      ERR     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ACK_N   <= !enter_ack;
`ifdef MEM_RESP_ERR_EN
      ERR     <= enter_ack && oob;
`endif
      if (state_q == S_IDLE && !AS_N) begin
        cnt_q  <= 4'(WAIT_CYC);
        addr_q <= ADDR;
        wr_n_q <= WR_N;
        di_q   <= DI;
      end else if (state_q == S_WAIT && !AS_N && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (enter_ack && wr_n_q) DO <= oob ? '0 : mem[idx];
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (reset_n && enter_ack && !wr_n_q && !oob) mem[idx] <= di_q;
  end
endmodule
